// File: rtl/bm_pkg.sv
// bm_pkg: shared states, default sizes and first-fault priority encoder for the beam-monitor trip path
package bm_pkg;
   typedef enum logic {ARMED = 1'b0, TRIPPED = 1'b1} state_t;
   localparam int NCH_DEF = 8;
   localparam int TS_W_DEF = 32;
   localparam int CNT_W_DEF = 16;
   function automatic int lowest_idx(input logic [63:0] v);
      lowest_idx = 0;
      for (int i = 0; i < 64; i++) if (v[63-i]) lowest_idx = 63 - i;
   endfunction
endpackage

// File: rtl/bm_rise_detect.sv
// bm_rise_detect: registered rising-edge detector, one bit per channel
module bm_rise_detect #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] rise
);
   logic [W-1:0] d_q;
   always_ff @(posedge clk) d_q <= reset ? '0 : d;
   assign rise = d & ~d_q;
endmodule

// File: rtl/bm_trip_latch.sv
// bm_trip_latch: latched trip with first-fault capture, timestamp, event count and clear refusal
module bm_trip_latch
   import bm_pkg::*;
#(
   parameter int NCH = NCH_DEF,
   parameter int TS_W = TS_W_DEF,
   parameter int CNT_W = CNT_W_DEF,
   localparam int IW = NCH > 1 ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NCH-1:0]   clean,
   input  logic [NCH-1:0]   polarity,
   input  logic [NCH-1:0]   mask,
   input  logic             clear,
   output logic             trip,
   output logic [NCH-1:0]   latched,
   output logic [NCH-1:0]   first_fault,
   output logic [IW-1:0]    first_idx,
   output logic [TS_W-1:0]  first_ts,
   output logic [CNT_W-1:0] trip_cnt,
   output logic             clear_nack
);
   state_t state_q, state_d;
   logic [NCH-1:0] fault, rise, latched_q, latched_d, ff_q, ff_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [TS_W-1:0] ts_q, ts_d, fts_q, fts_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic nack_q, nack_d;
   assign fault = ~(clean ^ polarity) & ~mask;
   bm_rise_detect #(.W(NCH)) u_rise (.clk(clk), .reset(reset), .d(fault), .rise(rise));
   always_comb begin
      state_d = state_q;
      latched_d = latched_q;
      ff_d = ff_q;
      idx_d = idx_q;
      fts_d = fts_q;
      nack_d = 1'b0;
      ts_d = ts_q + 1'b1;
      cnt_d = (|rise && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
      if (state_q == ARMED) begin
         if (|fault) begin
            state_d = TRIPPED;
            latched_d = fault;
            ff_d = fault;
            idx_d = IW'(lowest_idx(64'(fault)));
            fts_d = ts_q;
         end
      end else if (clear && !(|fault)) begin
         state_d = ARMED;
         latched_d = '0;
         ff_d = '0;
         idx_d = '0;
         fts_d = '0;
      end else begin
         // a fault present alongside clear keeps the trip and refuses the clear
         latched_d = latched_q | fault;
         nack_d = clear;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ARMED;
         latched_q <= '0;
         ff_q <= '0;
         idx_q <= '0;
         fts_q <= '0;
         ts_q <= '0;
         cnt_q <= '0;
         nack_q <= 1'b0;
      end else begin
         state_q <= state_d;
         latched_q <= latched_d;
         ff_q <= ff_d;
         idx_q <= idx_d;
         fts_q <= fts_d;
         ts_q <= ts_d;
         cnt_q <= cnt_d;
         nack_q <= nack_d;
      end
   end
   assign trip = state_q == TRIPPED;
   assign latched = latched_q;
   assign first_fault = ff_q;
   assign first_idx = idx_q;
   assign first_ts = fts_q;
   assign trip_cnt = cnt_q;
   assign clear_nack = nack_q;
endmodule

// File: tb/tb_bm_trip_latch.sv
// tb_bm_trip_latch: directed vectors for bm_trip_latch with hand-computed expectations
module tb_bm_trip_latch;
   logic clk = 1'b0, reset = 1'b1, clear = 1'b0;
   logic [7:0] clean = '0, polarity = 8'hFF, mask = '0;
   logic trip, clear_nack;
   logic [7:0] latched, first_fault;
   logic [2:0] first_idx;
   logic [31:0] first_ts;
   logic [15:0] trip_cnt;
   int n_chk = 0, n_pass = 0;
   int unsigned ts_m = 0, t0;
   bm_trip_latch dut (
      .clk(clk), .reset(reset), .clean(clean), .polarity(polarity), .mask(mask), .clear(clear),
      .trip(trip), .latched(latched), .first_fault(first_fault), .first_idx(first_idx),
      .first_ts(first_ts), .trip_cnt(trip_cnt), .clear_nack(clear_nack)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      else n_pass++;
   endtask
   task automatic step();
      @(posedge clk);
      ts_m = reset ? 0 : ts_m + 1;
      #1;
   endtask
   task automatic check_idle(input string tag);
      check({tag, "_trip"}, 64'(trip), 0);
      check({tag, "_latched"}, 64'(latched), 0);
      check({tag, "_ff"}, 64'(first_fault), 0);
      check({tag, "_idx"}, 64'(first_idx), 0);
      check({tag, "_ts"}, 64'(first_ts), 0);
      check({tag, "_nack"}, 64'(clear_nack), 0);
   endtask
   initial begin
      repeat (3) step();
      check_idle("rst");
      check("rst_cnt", 64'(trip_cnt), 0);
      reset = 1'b0;
      repeat (100) step();
      check("idle_trip", 64'(trip), 0);
      check("idle_cnt", 64'(trip_cnt), 0);
      clean = 8'h08;
      step();
      check("t2_trip", 64'(trip), 1);
      check("t2_ff", 64'(first_fault), 8'h08);
      check("t2_idx", 64'(first_idx), 3);
      check("t2_ts", 64'(first_ts), 100);
      check("t2_cnt", 64'(trip_cnt), 1);
      check("t2_latched", 64'(latched), 8'h08);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("t3_nack", 64'(clear_nack), 1);
      check("t3_trip_held", 64'(trip), 1);
      step();
      check("t3_nack_pulse", 64'(clear_nack), 0);
      clean = 8'h00;
      step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      check_idle("t3_clr");
      check("t3_cnt", 64'(trip_cnt), 1);
      clean = 8'h24;
      t0 = ts_m;
      step();
      check("t4_trip", 64'(trip), 1);
      check("t4_ff", 64'(first_fault), 8'h24);
      check("t4_idx", 64'(first_idx), 2);
      check("t4_ts", 64'(first_ts), 64'(t0));
      check("t4_cnt", 64'(trip_cnt), 2);
      clean = 8'hA4;
      step();
      check("t4_latched", 64'(latched), 8'hA4);
      check("t4_ff_frozen", 64'(first_fault), 8'h24);
      check("t4_ts_frozen", 64'(first_ts), 64'(t0));
      check("t4_cnt2", 64'(trip_cnt), 3);
      clean = 8'h00;
      step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("t4_clr", 64'(trip), 0);
      mask = 8'h40;
      clean = 8'h40;
      step();
      clean = 8'h00;
      step();
      clean = 8'h40;
      step();
      check("t5_mask_trip", 64'(trip), 0);
      check("t5_mask_cnt", 64'(trip_cnt), 3);
      polarity = 8'hFD;
      t0 = ts_m;
      step();
      check("t5_pol_trip", 64'(trip), 1);
      check("t5_pol_ff", 64'(first_fault), 8'h02);
      check("t5_pol_idx", 64'(first_idx), 1);
      check("t5_pol_ts", 64'(first_ts), 64'(t0));
      check("t5_pol_cnt", 64'(trip_cnt), 4);
      mask = 8'h42;
      step();
      check("t5_latch_kept", 64'(latched), 8'h02);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check_idle("t5_mask_clr");
      polarity = 8'hFF;
      mask = 8'h00;
      clean = 8'h00;
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("armed_clr_nack", 64'(clear_nack), 0);
      check("armed_clr_trip", 64'(trip), 0);
      step();
      for (int i = 0; i < 65531; i++) begin
         clean = i[0] ? 8'h02 : 8'h01;
         step();
      end
      check("t6_cnt_max", 64'(trip_cnt), 16'hFFFF);
      check("t6_trip", 64'(trip), 1);
      for (int i = 0; i < 3; i++) begin
         clean = i[0] ? 8'h01 : 8'h02;
         step();
      end
      check("t6_cnt_sat", 64'(trip_cnt), 16'hFFFF);
      reset = 1'b1;
      clean = 8'h08;
      step();
      check_idle("t6_rst");
      check("t6_rst_cnt", 64'(trip_cnt), 0);
      reset = 1'b0;
      step();
      check("lvl_trip", 64'(trip), 1);
      check("lvl_ff", 64'(first_fault), 8'h08);
      check("lvl_ts", 64'(first_ts), 0);
      check("lvl_cnt", 64'(trip_cnt), 1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
